// File: rtl/branch_resolve_bht.sv
// EX-stage branch resolution: decodes comparator flags into a branch outcome,
// predicts from a table of 2-bit saturating counters, and flags mispredictions.
module branch_resolve_bht #(
  parameter int BHT_ENTRIES = 64,
  parameter int IDX_W       = 6,
  parameter int CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [31:0]      i_id_pc,
  output logic             o_id_pred_taken,
  input  logic             i_ex_valid,
  input  logic             i_ex_is_br,
  input  logic             i_ex_stall,
  input  logic [2:0]       i_ex_funct3,
  input  logic [31:0]      i_ex_pc,
  input  logic [31:0]      i_ex_target,
  input  logic             i_ex_pred_taken,
  output logic             o_br_un,
  input  logic             i_br_less,
  input  logic             i_br_equal,
  output logic             o_ex_taken,
  output logic             o_redirect,
  output logic [31:0]      o_redirect_pc,
  output logic             o_flush,
  output logic [CNT_W-1:0] o_br_count,
  output logic [CNT_W-1:0] o_mispred_count
);

  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [1:0]       ctr_cur;
  logic [1:0]       ctr_d;
  logic             active;
  logic             legal;
  logic             outcome;
  logic             fire;
  logic             mispred;
  logic [31:0]      seq_pc;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;
  logic             id_pc_unused;

  // Only the index bits of the ID PC address the table.
  assign id_pc_unused = ^{i_id_pc[31:IDX_W+2], i_id_pc[1:0]};

  assign rd_idx          = i_id_pc[IDX_W+1:2];
  assign wr_idx          = i_ex_pc[IDX_W+1:2];
  assign o_id_pred_taken = bht_q[rd_idx][1];
  assign o_br_un         = i_ex_funct3[2] & i_ex_funct3[1];

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    legal   = 1'b1;
    outcome = 1'b0;
    case (i_ex_funct3)
      3'b000:         outcome = i_br_equal;
      3'b001:         outcome = !i_br_equal;
      3'b100, 3'b110: outcome = i_br_less;
      3'b101, 3'b111: outcome = !i_br_less;
      default:        legal   = 1'b0;
    endcase
  end

  // Gating with the reset keeps redirect/flush low while the core is held.
  assign active        = i_reset & i_ex_valid & i_ex_is_br;
  assign o_ex_taken    = active & outcome;
  assign fire          = active & !i_ex_stall & legal;
  assign mispred       = fire & (o_ex_taken != i_ex_pred_taken);
  assign seq_pc        = i_ex_pc + 32'd4;
  assign o_redirect    = mispred;
  assign o_flush       = mispred;
  assign o_redirect_pc = (mispred && o_ex_taken) ? i_ex_target : seq_pc;

  always_comb begin
    ctr_cur = bht_q[wr_idx];
    ctr_d   = ctr_cur;
    if (o_ex_taken) begin
      if (ctr_cur != 2'b11) ctr_d = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != 2'b00) ctr_d = ctr_cur - 2'd1;
    end
  end

  assign br_cnt_d  = br_cnt_q + CNT_W'(1);
  assign mis_cnt_d = mispred ? mis_cnt_q + CNT_W'(1) : mis_cnt_q;

  // NOTE: the counter table is a flop array rather than a RAM because every
  // entry must return to weakly-not-taken on reset; a RAM macro cannot do that.
  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else if (fire) begin
      bht_q[wr_idx] <= ctr_d;
      br_cnt_q      <= br_cnt_d;
      mis_cnt_q     <= mis_cnt_d;
    end
  end

  assign o_br_count      = br_cnt_q;
  assign o_mispred_count = mis_cnt_q;

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Bench for branch_resolve_bht: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_branch_resolve_bht;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] id_pc = '0;
  logic        id_pred;
  logic        ex_valid = 1'b0, ex_is_br = 1'b0, ex_stall = 1'b0;
  logic [2:0]  ex_f3 = '0;
  logic [31:0] ex_pc = '0, ex_target = '0;
  logic        ex_pred = 1'b0;
  logic        br_un, br_less = 1'b0, br_equal = 1'b0;
  logic        ex_taken, redirect, flush;
  logic [31:0] redirect_pc;
  logic [31:0] br_count, mis_count;

  int checks = 0;
  int errors = 0;

  // Reference state: counter values 0..3 per index, plain event tallies.
  int          m_bht [64];
  logic [31:0] m_br;
  logic [31:0] m_mis;

  branch_resolve_bht #(.BHT_ENTRIES(64), .IDX_W(6), .CNT_W(32)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_id_pc(id_pc), .o_id_pred_taken(id_pred),
    .i_ex_valid(ex_valid), .i_ex_is_br(ex_is_br), .i_ex_stall(ex_stall),
    .i_ex_funct3(ex_f3), .i_ex_pc(ex_pc), .i_ex_target(ex_target),
    .i_ex_pred_taken(ex_pred), .o_br_un(br_un), .i_br_less(br_less),
    .i_br_equal(br_equal), .o_ex_taken(ex_taken), .o_redirect(redirect),
    .o_redirect_pc(redirect_pc), .o_flush(flush), .o_br_count(br_count),
    .o_mispred_count(mis_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic logic outcome_of(input logic [2:0] f3, input logic less, input logic eq);
    case (f3)
      3'd0: return eq;
      3'd1: return !eq;
      3'd4, 3'd6: return less;
      3'd5, 3'd7: return !less;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic legal_of(input logic [2:0] f3);
    return (f3 != 3'd2) && (f3 != 3'd3);
  endfunction

  // Model advance on the clock edge, from the inputs held across it.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) m_bht[i] = 1;
      m_br  = 0;
      m_mis = 0;
    end else if (ex_valid && ex_is_br && !ex_stall && legal_of(ex_f3)) begin
      logic t;
      int   k;
      t = outcome_of(ex_f3, br_less, br_equal);
      k = idx_of(ex_pc);
      m_bht[k] = t ? ((m_bht[k] < 3) ? m_bht[k] + 1 : 3)
                   : ((m_bht[k] > 0) ? m_bht[k] - 1 : 0);
      m_br = m_br + 1;
      if (t != ex_pred) m_mis = m_mis + 1;
    end
  end

  // Every-cycle comparison, midway between edges.
  always @(negedge clk) begin
    logic e_taken, e_fire, e_mis, e_pred;
    logic [31:0] e_rpc;
    e_taken = rst_n && ex_valid && ex_is_br && outcome_of(ex_f3, br_less, br_equal);
    e_fire  = rst_n && ex_valid && ex_is_br && !ex_stall && legal_of(ex_f3);
    e_mis   = e_fire && (e_taken != ex_pred);
    e_rpc   = (e_mis && e_taken) ? ex_target : ex_pc + 32'd4;
    e_pred  = rst_n ? (m_bht[idx_of(id_pc)] >= 2) : 1'b0;
    check("cmp_pred",     {31'd0, id_pred},  {31'd0, e_pred});
    check("cmp_br_un",    {31'd0, br_un},    {31'd0, ex_f3[2] & ex_f3[1]});
    check("cmp_taken",    {31'd0, ex_taken}, {31'd0, e_taken});
    check("cmp_redirect", {31'd0, redirect}, {31'd0, e_mis});
    check("cmp_flush",    {31'd0, flush},    {31'd0, e_mis});
    check("cmp_rpc",      redirect_pc,       e_rpc);
    check("cmp_br_cnt",   br_count,          rst_n ? m_br : 32'd0);
    check("cmp_mis_cnt",  mis_count,         rst_n ? m_mis : 32'd0);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] pc);
    ex_valid = 1'b0; ex_is_br = 1'b0; ex_stall = 1'b0; id_pc = pc;
  endtask

  task automatic br(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                    input logic less, input logic eq, input logic pred, input logic stall);
    ex_valid = 1'b1; ex_is_br = 1'b1; ex_f3 = f3; ex_pc = pc; ex_target = tgt;
    br_less = less; br_equal = eq; ex_pred = pred; ex_stall = stall;
  endtask

  initial begin
    // Reset state
    #2;
    id_pc = 32'h0;   #1; check("rst_pred_0",   {31'd0, id_pred}, 32'd0);
    id_pc = 32'h100; #1; check("rst_pred_100", {31'd0, id_pred}, 32'd0);
    id_pc = 32'hFC;  #1; check("rst_pred_fc",  {31'd0, id_pred}, 32'd0);
    check("rst_br_cnt", br_count, 32'd0);
    check("rst_mis_cnt", mis_count, 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    idle(32'h0);

    // Mispredicted taken BEQ
    cyc(); br(3'b000, 32'h40, 32'h80, 1'b0, 1'b1, 1'b0, 1'b0); #1;
    check("beq_redirect", {31'd0, redirect}, 32'd1);
    check("beq_rpc", redirect_pc, 32'h80);
    check("beq_flush", {31'd0, flush}, 32'd1);
    cyc(); idle(32'h40); #1;
    check("beq_pred_after", {31'd0, id_pred}, 32'd1);
    check("beq_br_cnt", br_count, 32'd1);
    check("beq_mis_cnt", mis_count, 32'd1);

    // Correctly predicted not-taken BLTU
    cyc(); br(3'b110, 32'h44, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    check("bltu_un", {31'd0, br_un}, 32'd1);
    check("bltu_taken", {31'd0, ex_taken}, 32'd0);
    check("bltu_redirect", {31'd0, redirect}, 32'd0);
    check("bltu_rpc", redirect_pc, 32'h48);
    cyc(); idle(32'h44); #1;
    check("bltu_pred", {31'd0, id_pred}, 32'd0);
    check("bltu_br_cnt", br_count, 32'd2);
    check("bltu_mis_cnt", mis_count, 32'd1);

    // Saturate index 16 upward, then one not-taken
    for (int i = 0; i < 4; i++) begin
      cyc(); br(3'b000, 32'h40, 32'h80, 1'b0, 1'b1, 1'b1, 1'b0); #1;
      check("sat_no_redirect", {31'd0, redirect}, 32'd0);
    end
    cyc(); br(3'b000, 32'h40, 32'h80, 1'b0, 1'b0, 1'b1, 1'b0); #1;
    check("sat_nt_redirect", {31'd0, redirect}, 32'd1);
    check("sat_nt_rpc", redirect_pc, 32'h44);
    cyc(); idle(32'h40); #1;
    check("sat_pred_10", {31'd0, id_pred}, 32'd1);
    check("sat_br_cnt", br_count, 32'd7);
    check("sat_mis_cnt", mis_count, 32'd2);

    // Index 17 sits at 00: one taken only reaches 01
    cyc(); br(3'b100, 32'h44, 32'h400, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    check("idx17_rpc", redirect_pc, 32'h400);
    cyc(); idle(32'h44); #1;
    check("idx17_pred_01", {31'd0, id_pred}, 32'd0);

    // Stalled mispredicted BNE: silent while held, one event on release
    for (int i = 0; i < 3; i++) begin
      cyc(); br(3'b001, 32'h48, 32'h300, 1'b0, 1'b0, 1'b0, 1'b1); #1;
      check("stall_redirect", {31'd0, redirect}, 32'd0);
      check("stall_flush", {31'd0, flush}, 32'd0);
    end
    check("stall_br_cnt", br_count, 32'd8);
    cyc(); ex_stall = 1'b0; #1;
    check("unstall_redirect", {31'd0, redirect}, 32'd1);
    check("unstall_rpc", redirect_pc, 32'h300);
    cyc(); idle(32'h48); #1;
    check("unstall_br_cnt", br_count, 32'd9);
    check("unstall_mis_cnt", mis_count, 32'd4);
    check("unstall_pred", {31'd0, id_pred}, 32'd1);

    // Illegal funct3
    cyc(); br(3'b010, 32'h4C, 32'h500, 1'b1, 1'b1, 1'b1, 1'b0); #1;
    check("ill_taken", {31'd0, ex_taken}, 32'd0);
    check("ill_redirect", {31'd0, redirect}, 32'd0);
    cyc(); idle(32'h4C); #1;
    check("ill_br_cnt", br_count, 32'd9);
    check("ill_mis_cnt", mis_count, 32'd4);
    check("ill_pred", {31'd0, id_pred}, 32'd0);

    // Randomized traffic with a mid-stream reset
    for (int n = 0; n < 3000; n++) begin
      cyc();
      ex_valid  = ($urandom_range(0, 9) < 8);
      ex_is_br  = ($urandom_range(0, 9) < 8);
      ex_stall  = ($urandom_range(0, 3) == 0);
      ex_f3     = 3'($urandom_range(0, 7));
      ex_pc     = (($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2));
      if ($urandom_range(0, 49) == 0) ex_pc = 32'hFFFF_FFFC;
      ex_target = $urandom & 32'hFFFF_FFFC;
      br_less   = 1'($urandom);
      br_equal  = 1'($urandom);
      ex_pred   = 1'($urandom);
      id_pc     = ($urandom_range(0, 2) == 0) ? ex_pc
                                              : (32'($urandom_range(0, 15)) << 2);
      if (n == 1500) begin
        ex_valid = 1'b1; ex_is_br = 1'b1; ex_stall = 1'b0; ex_f3 = 3'b000;
        br_equal = 1'b1; ex_pred = 1'b0;
        rst_n = 1'b0; #1;
        check("midrst_redirect", {31'd0, redirect}, 32'd0);
        check("midrst_flush", {31'd0, flush}, 32'd0);
        check("midrst_taken", {31'd0, ex_taken}, 32'd0);
        check("midrst_br_cnt", br_count, 32'd0);
        check("midrst_mis_cnt", mis_count, 32'd0);
        check("midrst_pred", {31'd0, id_pred}, 32'd0);
        cyc();
        rst_n = 1'b1;
      end
    end
    cyc();
    idle(32'h0);
    cyc();
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_bht.md
Name: branch_resolve_bht

Overview:
- EX-stage branch resolution block. It sits directly downstream of the branch comparator.
- It drives the comparator's unsigned-select input and consumes the comparator's less/equal flags to decide the branch outcome.
- A direct-mapped table of 2-bit saturating counters supplies the taken/not-taken prediction to the ID stage.
- On a misprediction it raises a pipeline redirect and a flush, and it keeps branch and misprediction statistics.

Parameters:
- BHT_ENTRIES, 64, number of 2-bit counters; must be a power of two.
- IDX_W, 6, index width; equals log2(BHT_ENTRIES); the index is pc[IDX_W+1:2].
- CNT_W, 32, width of each performance counter.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_id_pc  in  32  PC of the instruction in ID.
- o_id_pred_taken  out  1  prediction for i_id_pc; equals counter[idx][1].
- i_ex_valid  in  1  EX slot holds a live (non-bubble) instruction.
- i_ex_is_br  in  1  EX instruction is a conditional branch.
- i_ex_stall  in  1  EX is held this cycle.
- i_ex_funct3  in  3  branch funct3 of the EX instruction.
- i_ex_pc  in  32  PC of the EX instruction.
- i_ex_target  in  32  computed branch target, pc+imm.
- i_ex_pred_taken  in  1  prediction made in ID, carried down the pipeline.
- o_br_un  out  1  to the comparator: 1 for BLTU/BGEU, else 0.
- i_br_less  in  1  comparator less flag.
- i_br_equal  in  1  comparator equal flag.
- o_ex_taken  out  1  resolved branch outcome.
- o_redirect  out  1  misprediction; the fetch stage must load o_redirect_pc.
- o_redirect_pc  out  32  corrected PC.
- o_flush  out  1  kill the IF/ID and ID/EX registers; equals o_redirect.
- o_br_count  out  CNT_W  resolved branches since reset.
- o_mispred_count  out  CNT_W  mispredictions since reset.

Behaviour:
- Reset (async assert, sync release): every BHT counter goes to 2'b01 (weakly not-taken). Both perf counters go to 0. o_id_pred_taken reads 0 from every entry.
- Combinational outputs: o_br_un, o_ex_taken, o_redirect, o_redirect_pc and o_flush are combinational in the same cycle. o_redirect/o_flush must be 0 while i_reset is low.
- o_br_un: funct3[1] & funct3[2] (110, 111).
- Outcome decode (active = i_ex_valid & i_ex_is_br):
  - 000 BEQ: equal.
  - 001 BNE: !equal.
  - 100 BLT / 110 BLTU: less.
  - 101 BGE / 111 BGEU: !less.
  - 010, 011: outcome 0, no BHT update, not counted.
  - When not active, o_ex_taken = 0.
- Branch event: fire = active & !i_ex_stall & legal funct3.
- Mispredict: fire & (o_ex_taken != i_ex_pred_taken).
  - o_redirect = mispredict.
  - o_redirect_pc = o_ex_taken ? i_ex_target : i_ex_pc + 4 (modulo 2^32).
  - When o_redirect = 0, o_redirect_pc = i_ex_pc + 4.
- Stall: no redirect, no BHT update and no count while i_ex_stall = 1. Exactly one event is produced when the stall drops.
- BHT update on a rising edge with fire, at idx = i_ex_pc[IDX_W+1:2]:
  - Taken: counter saturates upward, 00->01->10->11->11.
  - Not taken: counter saturates downward, 11->10->01->00->00.
- Read/write same index in one cycle: o_id_pred_taken reflects the pre-update value (read-before-write). The new value is visible next cycle.
- Perf counters: o_br_count increments on fire; o_mispred_count increments on mispredict. Both wrap from all-ones to 0.
- No aliasing protection: PCs sharing an index share a counter.
- Reset mid-operation: table and counters return to reset values immediately, and outputs go low with no residual redirect.

Test Plan:
- Reset -> o_id_pred_taken=0 for i_id_pc=0x0,0x100,0xFC; o_br_count=0; o_mispred_count=0.
- BEQ at pc=0x40, equal=1, pred=0, target=0x80 -> o_redirect=1, o_redirect_pc=0x80, o_flush=1; next cycle counter[16]=10, i_id_pc=0x40 gives pred=1, counts 1/1.
- BLTU (funct3=110) -> o_br_un=1; less=0, pred=0 at pc=0x44 -> o_ex_taken=0, o_redirect=0, counter[17]=00, o_br_count+1, mispred unchanged.
- Four taken branches at pc=0x40, then a not-taken with pred=1 -> counter saturates at 11 then 10; final event redirect_pc=0x44.
- i_ex_stall held 3 cycles on a mispredicted BNE -> o_redirect=0 during the stall; exactly one redirect and one count after release.
- funct3=010 with valid=1 -> o_ex_taken=0, no redirect, counters unchanged. Also: i_reset low mid-stream -> all outputs and counters 0 immediately.
